// File: rtl/packet_tx_framer.sv
// Packet transmit framer: serialises header, source, destination and
// type-dependent payload words over a valid/ready stream.
module packet_tx_framer #(
    parameter int SEQ_W = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [2:0]  fPktType,
    input  logic [15:0] myNodeID,
    input  logic [15:0] destinationID,
    input  logic [15:0] pl0,
    input  logic [15:0] pl1,
    input  logic [15:0] pl2,
    input  logic [15:0] pl3,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic        done,
    output logic        err_type
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SRC,
        DST,
        PAY,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_type;
    logic [2:0]       r_plcnt;
    logic [15:0]      r_src;
    logic [15:0]      r_dst;
    logic [3:0][15:0] r_pl;
    logic [1:0]       r_idx;
    logic [SEQ_W-1:0] r_seq;
    logic             r_err;

    logic             w_start_ok;
    logic             w_bad_type;
    logic             w_fire;
    logic             w_pay_last;
    logic [7:0]       w_seq8;

    function automatic logic [2:0] f_plcnt(input logic [2:0] t);
        case (t)
            3'b000:  f_plcnt = 3'd4;
            3'b010:  f_plcnt = 3'd2;
            3'b100:  f_plcnt = 3'd1;
            3'b101:  f_plcnt = 3'd2;
            3'b110:  f_plcnt = 3'd2;
            default: f_plcnt = 3'd0;
        endcase
    endfunction

    assign w_bad_type = (fPktType == 3'b111);
    assign w_start_ok = (r_state == IDLE) && start && !w_bad_type;
    assign w_fire     = tx_valid && tx_ready;
    assign w_pay_last = (({1'b0, r_idx} + 3'd1) == r_plcnt);
    // Header carries 8 seq bits whatever the counter width
    assign w_seq8     = 8'(r_seq);

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign err_type = r_err;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_data  = 16'h0000;
        tx_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {r_type, r_plcnt, 2'b00, w_seq8};
                if (w_fire) w_next = SRC;
            end
            SRC: begin
                tx_valid = 1'b1;
                tx_data  = r_src;
                if (w_fire) w_next = DST;
            end
            DST: begin
                tx_valid = 1'b1;
                tx_data  = r_dst;
                tx_last  = (r_plcnt == 3'd0);
                if (w_fire) w_next = (r_plcnt == 3'd0) ? DONE : PAY;
            end
            PAY: begin
                tx_valid = 1'b1;
                tx_data  = r_pl[r_idx];
                tx_last  = w_pay_last;
                if (w_fire && w_pay_last) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_type  <= 3'd0;
            r_plcnt <= 3'd0;
            r_src   <= 16'h0000;
            r_dst   <= 16'h0000;
            r_pl    <= '0;
            r_idx   <= 2'd0;
            r_seq   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && w_bad_type;
            if (w_start_ok) begin
                r_type  <= fPktType;
                r_plcnt <= f_plcnt(fPktType);
                r_src   <= myNodeID;
                r_dst   <= destinationID;
                r_pl    <= {pl3, pl2, pl1, pl0};
                r_idx   <= 2'd0;
            end
            if (r_state == PAY && w_fire) begin
                r_idx <= r_idx + 2'd1;
            end
            if (r_state == DONE) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_tx_framer.sv
// Directed bench for packet_tx_framer: word order, stalls, seq wrap,
// bad type and mid-packet reset.
module tb_packet_tx_framer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [2:0]  fPktType;
    logic [15:0] myNodeID;
    logic [15:0] destinationID;
    logic [15:0] pl0, pl1, pl2, pl3;
    logic        tx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        busy;
    logic        done;
    logic        err_type;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_seq = 8'h00;

    packet_tx_framer #(.SEQ_W(8)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .fPktType      (fPktType),
        .myNodeID      (myNodeID),
        .destinationID (destinationID),
        .pl0           (pl0),
        .pl1           (pl1),
        .pl2           (pl2),
        .pl3           (pl3),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .busy          (busy),
        .done          (done),
        .err_type      (err_type)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sends one packet and checks every accepted word against the
    // expected order: header, src, dst, pl0 upward.
    task automatic send(input string tag, input logic [2:0] t,
                        input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3,
                        input logic [15:0] hdr, input int n,
                        input logic [31:0] rdy, input int ncyc,
                        input bit junk);
        logic [7:0][15:0] ew;
        logic [16:0]      prev;
        bit               stall;
        int               k;
        int               c;
        ew = {16'h0, p3, p2, p1, p0, dst, src, hdr};
        fPktType = t; myNodeID = src; destinationID = dst;
        pl0 = p0; pl1 = p1; pl2 = p2; pl3 = p3;
        tx_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        if (junk) begin
            fPktType = 3'b111; myNodeID = 16'hDEAD;
            destinationID = 16'hBEEF;
            pl0 = 16'h1111; pl1 = 16'h2222;
            pl2 = 16'h3333; pl3 = 16'h4444;
            start = 1'b1;
        end
        k = 0; c = 0; stall = 0; prev = '0;
        while (k < n && c < 32) begin
            tx_ready = rdy[c];
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            if (junk && c == 1) chk({tag, "_noerr"}, 32'(err_type), 32'd0);
            if (stall) chk({tag, "_hold"}, 32'({tx_last, tx_data}), 32'(prev));
            if (tx_ready) begin
                chk({tag, "_w"}, 32'(tx_data), 32'(ew[k]));
                chk({tag, "_last"}, 32'(tx_last), 32'(k == n - 1));
                k++;
                stall = 0;
            end else begin
                stall = 1;
                prev = {tx_last, tx_data};
            end
            tick;
            c++;
            start = 1'b0;
        end
        chk({tag, "_words"}, 32'(k), 32'(n));
        chk({tag, "_cycles"}, 32'(c), 32'(ncyc));
        tx_ready = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_dvalid"}, 32'(tx_valid), 32'd0);
        fPktType = 3'b101;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        nrst = 1'b1; start = 1'b0; fPktType = 3'd0;
        myNodeID = 16'h0; destinationID = 16'h0;
        pl0 = 16'h0; pl1 = 16'h0; pl2 = 16'h0; pl3 = 16'h0;
        tx_ready = 1'b0;
        tick;
        tick;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_type), 32'd0);
        nrst = 1'b0;
        tick;

        // CHE: 001 000 00 seq0
        send("che", 3'b001, 16'h0101, 16'h0202, 16'h0, 16'h0, 16'h0,
             16'h0, 16'h2000, 3, 32'hFFFF_FFFF, 3, 0);
        // DATA: 101 010 00 seq1
        send("data", 3'b101, 16'h0005, 16'h0009, 16'hAAAA, 16'hBBBB,
             16'hCCCC, 16'hDDDD, 16'hA801, 5, 32'hFFFF_FFFF, 5, 0);
        // HB with ready 1,0,0,1,... and a start attempt mid-packet
        send("hb", 3'b000, 16'h1234, 16'h5678, 16'hA0A0, 16'hB1B1,
             16'hC2C2, 16'hD3D3, 16'h1002, 7, 32'hFFFF_FFF9, 9, 1);

        fPktType = 3'b111;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("err_pulse", 32'(err_type), 32'd1);
        chk("err_valid", 32'(tx_valid), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        tick;
        chk("err_off", 32'(err_type), 32'd0);
        chk("err_valid2", 32'(tx_valid), 32'd0);

        // INV: 010 010 00 seq3; CHT: 100 001 00 seq4
        send("inv", 3'b010, 16'h00AA, 16'h00BB, 16'h7777, 16'h8888,
             16'h0, 16'h0, 16'h4803, 5, 32'hFFFF_FFFF, 5, 0);
        send("cht", 3'b100, 16'h00CC, 16'h00DD, 16'h9999, 16'hEEEE,
             16'h0, 16'h0, 16'h8404, 4, 32'hFFFF_FFFF, 4, 0);

        // SOS aborted by reset during payload
        fPktType = 3'b110; myNodeID = 16'h0042;
        destinationID = 16'h0043; pl0 = 16'h5151; pl1 = 16'h6262;
        start = 1'b1;
        tick;
        start = 1'b0;
        tx_ready = 1'b1;
        chk("sos_hdr", 32'(tx_data), 32'h0000_C805);
        tick;
        tick;
        tick;
        chk("sos_pay_valid", 32'(tx_valid), 32'd1);
        chk("sos_pay0", 32'(tx_data), 32'h0000_5151);
        tx_ready = 1'b0;
        nrst = 1'b1;
        tick;
        nrst = 1'b0;
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        chk("abort_last", 32'(tx_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick;
        chk("abort_done2", 32'(done), 32'd0);
        exp_seq = 8'h00;

        // MR: 011 000 00; 257 sends, seq 0..255 then 0
        for (int i = 0; i < 257; i++) begin
            send("mr", 3'b011, 16'h0A0A, 16'h0B0B, 16'h0, 16'h0,
                 16'h0, 16'h0, {8'h60, exp_seq}, 3, 32'hFFFF_FFFF,
                 3, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
